led_pwm: RTL and testbench
==========================

// Module: led_pwm
// PURPOSE
//   Multi-channel PWM LED driver on the byte-wide peripheral register bus.
//   Each channel has a CPU-writable duty register and a common period counter
//   with a programmable prescaler. Duty changes take effect only at period
//   boundaries, so outputs never glitch. Replaces the fixed 3-LED driver.
// PARAMETERS
//   CHANNELS  3  number of LED outputs (1..13)
//   PWM_W     8  period counter / duty width (1..8); period = 2**PWM_W slots
//   PRESC_W   8  prescaler width (<= 8)
//   ADDR_W    4  register address width; CHANNELS+3 <= 2**ADDR_W
// PORTS
//   clk       in   1         system clock, single clock domain
//   rst       in   1         synchronous active-high reset
//   rd_en     in   1         read strobe
//   addr      in   ADDR_W    register address, shared by read and write
//   rd_data   out  8         read data, valid with rd_valid
//   rd_valid  out  1         one-cycle pulse, 1 clk after rd_en
//   wr_en     in   1         write strobe
//   wr_data   in   8         write data
//   led       out  CHANNELS  PWM outputs, bit i = channel i, registered
// BEHAVIOUR
//   Register map: 0 CTRL (b0 enable, b1 invert), 1 PRESC, 2 FADE_STEP,
//     3+i DUTY[i] (low PWM_W bits used, upper bits read back 0).
//   Reset (rst=1 at posedge): all registers, shadows, counters, rd_data,
//     rd_valid, led cleared to 0. Reset mid-period aborts the period.
//   Read: rd_en at cycle t -> rd_data/rd_valid at t+1. rd_valid is 0 otherwise.
//     rd_data holds its value between reads. Unmapped addr reads 0.
//     DUTY reads return the written value, not the shadow.
//   Write: wr_en updates the register at the clock edge; unmapped addr ignored.
//     Read and write of the same addr in the same cycle: the read returns the old value.
//   Prescaler pcnt: 0..PRESC, tick when pcnt==PRESC, then wraps to 0.
//     PRESC=0 -> tick every clk.
//   Period counter n: PWM_W bits, advances only on tick, wraps max->0.
//   Period boundary = tick with n==max. On a boundary each shadow[i] loads DUTY[i].
//   led[i] <= enable & (n < shadow[i]), XORed with invert; 1 clk registered.
//     shadow=0 -> constant off; shadow=max -> on for max of 2**PWM_W slots.
//   enable=0: counters keep running; led = invert ? all 1 : all 0.
//   Writing PRESC does not reset pcnt. If pcnt > new PRESC, pcnt wraps via
//     overflow (no tick until the wrap).
// CONFIGURATION
//   LED_PWM_FADE_EN defined: on a boundary, shadow moves toward DUTY[i] by at
//     most FADE_STEP (saturating, never overshoots). FADE_STEP=0 -> immediate load.
//   Not defined: shadow loads DUTY[i] directly. FADE_STEP reads 0 and writes
//     to it are ignored.
// STRUCTURE
//   led_pkg: register offsets (REG_CTRL, REG_PRESC, REG_FADE, REG_DUTY0) and
//     CTRL bit indices.
//   Sub-module led_pwm_chan, one instance per channel via generate. It holds
//     shadow, fade step and compare against n. The top holds the register file,
//     the prescaler, n and the bus logic.
// TESTING
//   Reset: drive rst 2 clk with wr_en=1 -> all led=0, rd_valid=0, and all
//     registers read 0 after reset.
//   Readback: write DUTY0=0x40, CTRL=0x01, then rd_en at addr 3 -> rd_data=0x40,
//     rd_valid high exactly 1 clk. Reading addr 15 -> 0.
//   Duty: PRESC=0, PWM_W=8, DUTY0=64, DUTY1=0, DUTY2=255 -> per 256-clk period
//     led0 high 64 clk, led1 never high, led2 high 255 clk.
//   Glitch-free update: write DUTY0 mid-period -> current period unchanged,
//     new width starts at the next n==0.
//   Prescaler/invert: PRESC=3, CTRL=0x03, DUTY0=128 -> period 1024 clk,
//     led0 low 512 clk.
//   Fade (LED_PWM_FADE_EN): FADE_STEP=16, DUTY0 0->64 -> on-time 16, 32, 48, 64
//     in successive periods.

Source files
------------

// File: rtl/led_pkg.sv
// Register map offsets and CTRL bit positions shared by the LED PWM driver.
package led_pkg;

  localparam int unsigned REG_CTRL  = 0;
  localparam int unsigned REG_PRESC = 1;
  localparam int unsigned REG_FADE  = 2;
  localparam int unsigned REG_DUTY0 = 3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_INV = 1;

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: boundary-loaded duty shadow and registered compare output.
// LED_PWM_FADE_EN makes the shadow ramp toward the duty by at most the fade step.
module led_pwm_chan #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boundary,
  input  logic [PWM_W-1:0] duty,
  input  logic [7:0]       fade_step,
  input  logic [PWM_W-1:0] n,
  input  logic             enable,
  input  logic             invert,
  output logic             led
);

  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic             led_q, led_d;

`ifdef LED_PWM_FADE_EN
  logic [PWM_W-1:0] diff;
`else
  logic unused_fade;
  assign unused_fade = ^fade_step;
`endif

  always_comb begin
    shadow_d = shadow_q;
`ifdef LED_PWM_FADE_EN
    diff = (duty >= shadow_q) ? (duty - shadow_q) : (shadow_q - duty);
`endif
    if (boundary) begin
`ifdef LED_PWM_FADE_EN
      // Step is strictly smaller than the distance here, so truncation is safe.
      if (fade_step == 8'd0 || fade_step >= 8'(diff)) begin
        shadow_d = duty;
      end else if (duty > shadow_q) begin
        shadow_d = shadow_q + fade_step[PWM_W-1:0];
      end else begin
        shadow_d = shadow_q - fade_step[PWM_W-1:0];
      end
`else
      shadow_d = duty;
`endif
    end
    led_d = (enable && (n < shadow_q)) ^ invert;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm.sv
// Multi-channel PWM LED driver: register file, prescaler, period counter, bus.
// Optional fading of duty changes is enabled with LED_PWM_FADE_EN.
module led_pwm
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned PRESC_W  = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic [CHANNELS-1:0] led
);

  logic [1:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [PWM_W-1:0]   n_q, n_d;
  logic [PWM_W-1:0]   duty_q [CHANNELS];
  logic [PWM_W-1:0]   duty_d [CHANNELS];
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q;
  logic [7:0]         rdata;
  logic [7:0]         fade_step;
  logic               tick, boundary;

`ifdef LED_PWM_FADE_EN
  logic [7:0] fade_q, fade_d;
  assign fade_step = fade_q;
`else
  assign fade_step = 8'd0;
`endif

  // Read mux sees pre-write values, so a same-cycle read returns the old value.
  always_comb begin
    rdata = 8'd0;
    if (addr == ADDR_W'(REG_CTRL)) begin
      rdata = {6'd0, ctrl_q};
    end else if (addr == ADDR_W'(REG_PRESC)) begin
      rdata = 8'(presc_q);
    end else if (addr == ADDR_W'(REG_FADE)) begin
`ifdef LED_PWM_FADE_EN
      rdata = fade_q;
`endif
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (addr == ADDR_W'(REG_DUTY0 + i)) rdata = 8'(duty_q[i]);
      end
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    duty_d  = duty_q;
`ifdef LED_PWM_FADE_EN
    fade_d  = fade_q;
`endif
    if (wr_en) begin
      if (addr == ADDR_W'(REG_CTRL)) ctrl_d = wr_data[1:0];
      if (addr == ADDR_W'(REG_PRESC)) presc_d = wr_data[PRESC_W-1:0];
`ifdef LED_PWM_FADE_EN
      if (addr == ADDR_W'(REG_FADE)) fade_d = wr_data;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (addr == ADDR_W'(REG_DUTY0 + i)) duty_d[i] = wr_data[PWM_W-1:0];
      end
    end
    rd_data_d = rd_en ? rdata : rd_data_q;
  end

  // Lowering PRESC below pcnt lets pcnt run on and wrap by overflow.
  always_comb begin
    tick     = (pcnt_q == presc_q);
    pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
    n_d      = tick ? n_q + 1'b1 : n_q;
    boundary = tick && (n_q == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      n_q        <= '0;
      duty_q     <= '{default: '0};
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef LED_PWM_FADE_EN
      fade_q     <= '0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      n_q        <= n_d;
      duty_q     <= duty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
`ifdef LED_PWM_FADE_EN
      fade_q     <= fade_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    led_pwm_chan #(
      .PWM_W(PWM_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .boundary (boundary),
      .duty     (duty_q[g]),
      .fade_step(fade_step),
      .n        (n_q),
      .enable   (ctrl_q[CTRL_EN]),
      .invert   (ctrl_q[CTRL_INV]),
      .led      (led[g])
    );
  end

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: register table, hand-written PWM sequences and
// randomized bus traffic checked every cycle against a behavioural model.
module tb_led_pwm;

  localparam int NCH    = 3;
  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [2:0] led;

  led_pwm dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .addr    (addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .led     (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register image, slot position within the period, shadows.
  int       m_ctrl, m_presc, m_fade, m_pcnt, m_n;
  int       m_duty [NCH];
  int       m_sh   [NCH];
  logic [2:0] exp_led = '0;
  logic       exp_rv  = 1'b0;
  logic [7:0] exp_rd  = '0;

  function automatic int regval(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_presc;
`ifdef LED_PWM_FADE_EN
      2: return m_fade;
`endif
      3, 4, 5: return m_duty[a-3];
      default: return 0;
    endcase
  endfunction

  function automatic int next_shadow(input int sh, input int target);
`ifdef LED_PWM_FADE_EN
    if (m_fade == 0) return target;
    if (sh < target) return (sh + m_fade > target) ? target : sh + m_fade;
    return (sh - m_fade < target) ? target : sh - m_fade;
`else
    return target;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ctrl = 0; m_presc = 0; m_fade = 0; m_pcnt = 0; m_n = 0;
      for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
      exp_led = '0; exp_rv = 1'b0; exp_rd = '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        exp_led[i] = ((m_ctrl % 2 == 1) && (m_n < m_sh[i])) ^ (m_ctrl / 2 == 1);
      exp_rv = rd_en;
      if (rd_en) exp_rd = 8'(regval(int'(addr)));
      if (m_pcnt == m_presc) begin
        if (m_n == PERIOD - 1)
          for (int i = 0; i < NCH; i++) m_sh[i] = next_shadow(m_sh[i], m_duty[i]);
        m_n    = (m_n + 1) % PERIOD;
        m_pcnt = 0;
      end else begin
        m_pcnt = (m_pcnt + 1) % 256;
      end
      if (wr_en) begin
        case (int'(addr))
          0: m_ctrl = int'(wr_data) % 4;
          1: m_presc = int'(wr_data);
`ifdef LED_PWM_FADE_EN
          2: m_fade = int'(wr_data);
`endif
          3, 4, 5: m_duty[int'(addr)-3] = int'(wr_data);
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("led_model", int'(led), int'(exp_led));
      check("rd_valid_model", int'(rd_valid), int'(exp_rv));
      check("rd_data_model", int'(rd_data), int'(exp_rd));
    end
  end

  // All bus tasks start and end at a falling edge.
  task automatic wr(input int a, input int d);
    wr_en = 1'b1; addr = 4'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, output int d);
    rd_en = 1'b1; addr = 4'(a);
    @(negedge clk);
    rd_en = 1'b0;
    d = int'(rd_data);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b1; addr = 4'd3; wr_data = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_n(input int target, input string name);
    int k = 0;
    while (m_n != target && k < 4 * PERIOD * 4) begin @(negedge clk); k++; end
    check(name, int'(m_n == target), 1);
  endtask

  task automatic count_led(input int ch, input int cycles, input bit want, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      if (led[ch] == want) cnt++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int addr;
    int wdata;
    int rexp;
  } vec_t;

  vec_t vecs [9];
  int   got, cnt;

  initial begin
    vecs[0] = '{0, 8'hFF, 8'h03};
    vecs[1] = '{1, 8'hA5, 8'hA5};
`ifdef LED_PWM_FADE_EN
    vecs[2] = '{2, 8'h10, 8'h10};
`else
    vecs[2] = '{2, 8'h10, 8'h00};
`endif
    vecs[3] = '{3, 8'h40, 8'h40};
    vecs[4] = '{4, 8'h00, 8'h00};
    vecs[5] = '{5, 8'hFF, 8'hFF};
    vecs[6] = '{6, 8'h12, 8'h00};
    vecs[7] = '{15, 8'h77, 8'h00};
    vecs[8] = '{0, 8'h02, 8'h02};

    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    check("reset_led", int'(led), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    for (int a = 0; a < 6; a++) begin
      rd(a, got);
      check($sformatf("reset_reg%0d", a), got, 0);
    end

    // Register table: write then read back.
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, got);
      check($sformatf("table_%0d_addr%0d", i, vecs[i].addr), got, vecs[i].rexp);
    end

    // Readback and one-cycle rd_valid pulse.
    do_reset();
    wr(3, 8'h40);
    wr(0, 8'h01);
    rd(3, got);
    check("readback_duty0", got, 8'h40);
    check("readback_valid_hi", int'(rd_valid), 1);
    @(negedge clk);
    check("readback_valid_lo", int'(rd_valid), 0);
    check("readback_hold", int'(rd_data), 8'h40);
    rd(15, got);
    check("readback_unmapped", got, 0);

    // Duty widths with PRESC=0.
    wr(4, 0);
    wr(5, 255);
    repeat (2 * PERIOD + 10) @(negedge clk);
    count_led(0, PERIOD, 1'b1, cnt); check("duty64_on", cnt, 64);
    count_led(1, PERIOD, 1'b1, cnt); check("duty0_on", cnt, 0);
    count_led(2, PERIOD, 1'b1, cnt); check("duty255_on", cnt, 255);

    // Mid-period duty change must not alter the current period.
    wait_n(128, "wait_mid");
    wr(3, 200);
    cnt = 0;
    for (int k = 0; k < 2 * PERIOD && m_n != 1; k++) begin
      if (led[0]) cnt++;
      @(negedge clk);
    end
    check("glitch_tail_on", cnt, 0);
    check("glitch_reached_n1", m_n, 1);
    count_led(0, PERIOD, 1'b1, cnt); check("glitch_new_on", cnt, 200);

    // Prescaler and invert.
    wr(3, 128);
    wr(1, 3);
    wr(0, 3);
    repeat (2 * 4 * PERIOD + 20) @(negedge clk);
    count_led(0, 4 * PERIOD, 1'b0, cnt); check("presc_inv_low", cnt, 512);
    count_led(1, 4 * PERIOD, 1'b1, cnt); check("presc_inv_duty0_high", cnt, 1024);

`ifdef LED_PWM_FADE_EN
    do_reset();
    wr(2, 16);
    wr(0, 1);
    wr(3, 64);
    wait_n(1, "fade_align");
    for (int p = 1; p <= 4; p++) begin
      count_led(0, PERIOD, 1'b1, cnt);
      check($sformatf("fade_period%0d", p), cnt, 16 * p);
    end
`endif

    // Randomized bus traffic; the model checker runs every cycle.
    do_reset();
    wr(0, 1);
    for (int k = 0; k < 4000; k++) begin
      int a;
      a       = $urandom_range(0, 15);
      addr    = 4'(a);
      rd_en   = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_data = (a == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      @(negedge clk);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
